// File: rtl/row_loader_if.sv
// Row output channel of row_loader.
// The producer (master) presents one assembled image row at a time. The consumer
// (slave) accepts that row with a valid/ready handshake.
//   row_out    : IM_W*BW bits. Column k is in bits [k*BW +: BW].
//   row_valid  : row_out holds a complete row.
//   row_ready  : consumer accepts the row.
//   row_idx    : index of the row that is being assembled or presented.
//   frame_done : one-cycle pulse after the last row of a sample is accepted.
interface row_loader_if #(
  parameter int BW   = 16,
  parameter int IM_W = 28,
  parameter int IM_H = 28
);
  localparam int IW = (IM_H > 1) ? $clog2(IM_H) : 1;

  logic [IM_W*BW-1:0] row_out;
  logic               row_valid;
  logic               row_ready;
  logic [IW-1:0]      row_idx;
  logic               frame_done;

  modport master (
    output row_out, row_valid, row_idx, frame_done,
    input  row_ready
  );

  modport slave (
    input  row_out, row_valid, row_idx, frame_done,
    output row_ready
  );
endinterface

// File: rtl/row_loader.sv
// row_loader: reads one image sample from a synchronous ROM, one pixel per cycle,
// and presents the sample row by row on a valid/ready channel.
//   clk         : single clock. State changes on the rising edge.
//   rst         : asynchronous reset, active low.
//   en          : fetch enable. While en is low, no new ROM address is issued.
//   next_sample : moves to the next sample (ss+1) and restarts it from row 0.
//                 It has priority over every other input.
//   rom_data    : ROM read data. It arrives 1 cycle after rom_addr.
//   rom_addr    : pixel address within the current sample. It stops at IM_W*IM_H.
//   ss          : sample select for the ROM bank.
//   rows        : row output channel (see row_loader_if).
module row_loader #(
  parameter int BW   = 16,
  parameter int IM_W = 28,
  parameter int IM_H = 28,
  parameter int AW   = 10,
  parameter int SSW  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           next_sample,
  input  logic [BW-1:0]  rom_data,
  output logic [AW-1:0]  rom_addr,
  output logic [SSW-1:0] ss,
  row_loader_if.master   rows
);
  localparam int IW = (IM_H > 1) ? $clog2(IM_H) : 1;
  localparam int CW = $clog2(IM_W + 1);
  localparam logic [CW-1:0] ROW_LEN  = CW'(IM_W);
  localparam logic [CW-1:0] LAST_COL = CW'(IM_W - 1);
  localparam logic [IW-1:0] LAST_ROW = IW'(IM_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      issued;
  logic [CW-1:0]      captured;
  logic               pending;
  logic [IM_W*BW-1:0] row_reg;
  logic               row_valid;
  logic [IW-1:0]      row_idx;
  logic               frame_done;

  logic issue;
  logic accept;
  logic last_capture;

  // Next-state logic and the per-cycle strobes that the datapath uses.
  always_comb begin
    state_next   = state;
    issue        = 1'b0;
    accept       = 1'b0;
    last_capture = pending && (captured == LAST_COL);
    if (next_sample) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // The IDLE cycle with en high is the first issue of the row.
          if (en) begin
            issue      = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: begin
          issue = en && (issued < ROW_LEN);
          if (last_capture) state_next = HOLD;
        end
        HOLD: begin
          if (row_valid && rows.row_ready) begin
            accept     = 1'b1;
            state_next = (row_idx == LAST_ROW) ? DONE : FETCH;
          end
        end
        DONE: state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr   <= '0;
      ss         <= '0;
      issued     <= '0;
      captured   <= '0;
      pending    <= 1'b0;
      row_reg    <= '0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else if (next_sample) begin
      // A read still in flight is dropped because pending is cleared here.
      // row_reg keeps its contents; the next row overwrites them.
      ss         <= ss + 1'b1;
      rom_addr   <= '0;
      issued     <= '0;
      captured   <= '0;
      pending    <= 1'b0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      pending    <= issue;
      if (issue) begin
        rom_addr <= rom_addr + 1'b1;
        issued   <= issued + 1'b1;
      end
      // New pixels enter at the top column and shift down, so column 0 ends up
      // holding the first pixel fetched.
      if (pending) begin
        row_reg  <= {rom_data, row_reg[IM_W*BW-1:BW]};
        captured <= captured + 1'b1;
        if (last_capture) row_valid <= 1'b1;
      end
      if (accept) begin
        row_valid <= 1'b0;
        if (row_idx == LAST_ROW) begin
          frame_done <= 1'b1;
        end else begin
          row_idx  <= row_idx + 1'b1;
          issued   <= '0;
          captured <= '0;
        end
      end
    end
  end

  assign rows.row_out    = row_reg;
  assign rows.row_valid  = row_valid;
  assign rows.row_idx    = row_idx;
  assign rows.frame_done = frame_done;
endmodule

// File: tb/tb_row_loader.sv
// Self-checking bench for row_loader. The configuration is BW=8, IM_W=4, IM_H=2.
// The ROM model returns addr+1.
module tb_row_loader;
  localparam int BW   = 8;
  localparam int IM_W = 4;
  localparam int IM_H = 2;
  localparam int AW   = 4;
  localparam int SSW  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           next_sample = 1'b0;
  logic [BW-1:0]  rom_data = '0;
  logic [AW-1:0]  rom_addr;
  logic [SSW-1:0] ss;

  row_loader_if #(.BW(BW), .IM_W(IM_W), .IM_H(IM_H)) rif ();

  row_loader #(.BW(BW), .IM_W(IM_W), .IM_H(IM_H), .AW(AW), .SSW(SSW)) dut (
    .clk(clk), .rst(rst_n), .en(en), .next_sample(next_sample),
    .rom_data(rom_data), .rom_addr(rom_addr), .ss(ss), .rows(rif)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of latency: pixel at address a is a+1.
  always @(posedge clk) rom_data <= 8'(rom_addr + 1);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Row r of any sample holds pixels r*IM_W+1 .. r*IM_W+IM_W, with column 0 first.
  function automatic logic [IM_W*BW-1:0] exp_row(input int r);
    logic [IM_W*BW-1:0] v;
    v = '0;
    for (int k = 0; k < IM_W; k++) v[k*BW +: BW] = 8'(r*IM_W + k + 1);
    return v;
  endfunction

  // Transaction-level reference. It counts pixels requested and received for the
  // current row, whether a row is being presented, and whether the sample is finished.
  int m_addr, m_ss, m_idx, m_req, m_got;
  bit m_inflight, m_valid, m_done, m_fin;
  bit m_can_req;
  assign m_can_req = en && !m_valid && !m_fin && (m_req < IM_W);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr <= 0; m_ss <= 0; m_idx <= 0; m_req <= 0; m_got <= 0;
      m_inflight <= 0; m_valid <= 0; m_done <= 0; m_fin <= 0;
    end else if (next_sample) begin
      m_ss <= (m_ss + 1) % (1 << SSW);
      m_addr <= 0; m_idx <= 0; m_req <= 0; m_got <= 0;
      m_inflight <= 0; m_valid <= 0; m_done <= 0; m_fin <= 0;
    end else begin
      m_done <= 0;
      if (m_valid && rif.row_ready) begin
        m_valid <= 0;
        if (m_idx == IM_H - 1) begin
          m_done <= 1; m_fin <= 1;
        end else begin
          m_idx <= m_idx + 1; m_req <= 0; m_got <= 0;
        end
      end
      if (m_inflight) begin
        m_got <= m_got + 1;
        if (m_got + 1 == IM_W) m_valid <= 1;
      end
      m_inflight <= m_can_req;
      if (m_can_req) begin
        m_addr <= m_addr + 1;
        m_req  <= m_req + 1;
      end
    end
  end

  // Record every accepted row and every frame_done pulse (values from before the edge).
  logic [IM_W*BW-1:0] acc_q[$];
  int fcount = 0;
  always @(posedge clk) begin
    if (rst_n && !next_sample && rif.row_valid && rif.row_ready) acc_q.push_back(rif.row_out);
    if (rst_n && rif.frame_done) fcount++;
  end

  // Compare the DUT against the reference on every cycle.
  always @(negedge clk) begin
    chk("rom_addr", rom_addr, m_addr);
    chk("ss", ss, m_ss);
    chk("row_valid", rif.row_valid, m_valid);
    chk("row_idx", rif.row_idx, m_idx);
    chk("frame_done", rif.frame_done, m_done);
    if (m_valid) chk("row_out", rif.row_out, exp_row(m_idx));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; next_sample = 1'b0; rif.row_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_ns();
    @(negedge clk); next_sample = 1'b1;
    @(negedge clk); next_sample = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!rif.row_valid && n < budget) begin @(negedge clk); n++; end
    if (!rif.row_valid) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for row_valid, expected within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_frame(input string name, input int budget);
    int n = 0;
    while (!rif.frame_done && n < budget) begin @(negedge clk); n++; end
    if (!rif.frame_done) begin
      tests++; fails++;
      $display("FAIL %s: timeout waiting for frame_done, expected within %0d cycles", name, budget);
    end
  endtask

  task automatic check_frame(input string tag, input int a0, input int f0);
    repeat (3) @(negedge clk);
    chk({tag, "_rows_accepted"}, acc_q.size() - a0, 2);
    chk({tag, "_row0"}, (acc_q.size() > a0) ? acc_q[a0] : '0, 32'h04030201);
    chk({tag, "_row1"}, (acc_q.size() > a0 + 1) ? acc_q[a0 + 1] : '0, 32'h08070605);
    chk({tag, "_frame_done_pulses"}, fcount - f0, 1);
    chk({tag, "_final_addr"}, rom_addr, 8);
  endtask

  initial begin
    int lat, a0, f0, n;
    rif.row_ready = 1'b0;
    do_reset();
    chk("reset_addr", rom_addr, 0);
    chk("reset_valid", rif.row_valid, 0);
    chk("reset_row_out", rif.row_out, 0);

    // Continuous en and ready.
    a0 = acc_q.size(); f0 = fcount;
    rif.row_ready = 1'b1; en = 1'b1;
    lat = 0;
    while (!rif.row_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("first_valid_latency", lat, 5);
    wait_frame("s1_frame", 30);
    check_frame("s1", a0, f0);
    repeat (4) @(negedge clk);
    chk("done_addr_holds", rom_addr, 8);

    // en toggles 1,0,1,0 while fetching.
    en = 1'b0;
    pulse_ns();
    a0 = acc_q.size(); f0 = fcount;
    for (int i = 0; i < 80 && !rif.frame_done; i++) begin
      en = (i % 2 == 0);
      @(negedge clk);
    end
    check_frame("s2", a0, f0);

    // Consumer stalls for 10 cycles while a row is held.
    en = 1'b0; rif.row_ready = 1'b0;
    pulse_ns();
    en = 1'b1;
    wait_valid("s3_valid", 20);
    repeat (10) @(negedge clk);
    chk("s3_hold_idx", rif.row_idx, 0);
    chk("s3_hold_addr", rom_addr, 4);
    chk("s3_hold_row", rif.row_out, 32'h04030201);
    chk("s3_hold_valid", rif.row_valid, 1);
    rif.row_ready = 1'b1;
    @(negedge clk);
    chk("s3_accept_valid", rif.row_valid, 0);
    chk("s3_accept_idx", rif.row_idx, 1);

    // next_sample while a read is pending on row 1.
    do_reset();
    rif.row_ready = 1'b1; en = 1'b1;
    n = 0;
    while (rif.row_idx != 1 && n < 20) begin @(negedge clk); n++; end
    chk("s4_reached_row1", rif.row_idx, 1);
    @(negedge clk);
    next_sample = 1'b1;
    @(negedge clk);
    next_sample = 1'b0;
    chk("s4_ss", ss, 1);
    chk("s4_addr", rom_addr, 0);
    chk("s4_valid", rif.row_valid, 0);
    chk("s4_idx", rif.row_idx, 0);
    rif.row_ready = 1'b0;
    wait_valid("s4_valid_again", 20);
    chk("s4_row0", rif.row_out, 32'h04030201);

    // Asynchronous reset while a row is held.
    do_reset();
    pulse_ns();
    pulse_ns();
    en = 1'b1; rif.row_ready = 1'b0;
    wait_valid("s7_valid", 20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s7_rst_valid", rif.row_valid, 0);
    chk("s7_rst_row_out", rif.row_out, 0);
    chk("s7_rst_addr", rom_addr, 0);
    chk("s7_rst_ss", ss, 0);
    chk("s7_rst_idx", rif.row_idx, 0);
    chk("s7_rst_frame_done", rif.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid("s7_after", 20);
    chk("s7_row0_after_reset", rif.row_out, 32'h04030201);

    // Random en, ready and occasional next_sample.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      en = ($urandom % 4) != 0;
      rif.row_ready = ($urandom % 3) != 0;
      next_sample = ($urandom % 60) == 0;
    end
    next_sample = 1'b0;

    // ss wraps from 15 to 0.
    do_reset();
    for (int i = 0; i < 15; i++) pulse_ns();
    chk("ss_at_15", ss, 15);
    pulse_ns();
    chk("ss_wrap", ss, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
